// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: decodes RV32 load/store requests, runs one
// req/ack transaction per access and stalls the pipeline until it completes.
module mem_stage_dmem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busywait_o,
    output logic [31:0]       rdata_o,
    output logic              misaligned_o,
    output logic              mm_req_o,
    output logic              mm_we_o,
    output logic [ADDR_W-1:0] mm_addr_o,
    output logic [3:0]        mm_be_o,
    output logic [31:0]       mm_wdata_o,
    input  logic              mm_ack_i,
    input  logic [31:0]       mm_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        req, illegal, valid, start, ld_en;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_data;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign req          = mem_read_i | mem_write_i;
    assign misaligned_o = rst_ni & req & illegal;
    assign valid        = rst_ni & req & ~illegal;
    assign mm_req_o     = (state_q == ACCESS);

    always_comb begin
        illegal = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = addr_i[0];
            3'b010:         illegal = |addr_i[1:0];
            default:        illegal = 1'b1;
        endcase
    end

    // Stores replicate data across lanes so memory only needs the byte enables.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        if (mem_write_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr_i[1:0];
                    wdata_d = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = wdata_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // DONE always returns to IDLE so the request still held by MEM cannot retrigger.
    always_comb begin
        state_d    = state_q;
        busywait_o = 1'b0;
        start      = 1'b0;
        ld_en      = 1'b0;
        case (state_q)
            IDLE: begin
                busywait_o = valid;
                if (valid) begin
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busywait_o = 1'b1;
                if (mm_ack_i) begin
                    ld_en   = ~mm_we_o;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_b = mm_rdata_i[{lane_q, 3'b000} +: 8];
        ld_h = lane_q[1] ? mm_rdata_i[31:16] : mm_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_data = {24'b0, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_data = {16'b0, ld_h};
            default: ld_data = mm_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mm_we_o    <= 1'b0;
            mm_addr_o  <= '0;
            mm_be_o    <= 4'b0;
            mm_wdata_o <= 32'b0;
            f3_q       <= 3'b0;
            lane_q     <= 2'b0;
            rdata_o    <= 32'b0;
        end else begin
            if (start) begin
                mm_we_o    <= mem_write_i;
                mm_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                mm_be_o    <= be_d;
                mm_wdata_o <= wdata_d;
                f3_q       <= funct3_i;
                lane_q     <= addr_i[1:0];
            end
            if (ld_en) rdata_o <= ld_data;
        end
    end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Bench for mem_stage_dmem_ctrl: table of load/store vectors against a memory
// responder, with a scoreboard of expected memory transactions.
module tb_mem_stage_dmem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busywait_o, misaligned_o;
    logic [31:0] rdata_o;
    logic        mm_req_o, mm_we_o;
    logic [31:0] mm_addr_o;
    logic [3:0]  mm_be_o;
    logic [31:0] mm_wdata_o;
    logic        mm_ack_i;
    logic [31:0] mm_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_stage_dmem_ctrl #(.ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busywait_o(busywait_o), .rdata_o(rdata_o), .misaligned_o(misaligned_o),
        .mm_req_o(mm_req_o), .mm_we_o(mm_we_o), .mm_addr_o(mm_addr_o),
        .mm_be_o(mm_be_o), .mm_wdata_o(mm_wdata_o),
        .mm_ack_i(mm_ack_i), .mm_rdata_i(mm_rdata_i)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mrdata;
        int          waits;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata, rdata;
        int          stall;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    int   checks = 0, failures = 0;
    int   req_rises = 0;
    logic req_prev = 1'b0;
    acc_t sb[$];
    vec_t tbl[16];

    always @(negedge clk_i) begin
        if (mm_req_o && !req_prev) req_rises++;
        req_prev = mm_req_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] mrdata, int waits,
                                logic mis, logic [31:0] maddr, logic [3:0] be,
                                logic [31:0] mwdata, logic [31:0] rdata, int stall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.mrdata = mrdata; v.waits = waits; v.mis = mis; v.maddr = maddr;
        v.be = be; v.mwdata = mwdata; v.rdata = rdata; v.stall = stall;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the op.
    task automatic run_op(input string nm, input vec_t v);
        int   stall = 0, served = 0;
        bit   seen = 0, done = 0;
        acc_t e, a;
        mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3;
        addr_i = v.addr; wdata_i = v.wdata;
        if (!v.mis) begin
            e.we = v.wr; e.addr = v.maddr; e.be = v.be; e.wdata = v.mwdata;
            sb.push_back(e);
        end
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk_i);
            if (cyc == 0) chk({nm, " misaligned"}, 32'(misaligned_o), 32'(v.mis));
            if (busywait_o) stall++;
            else done = 1;
            mm_ack_i = 1'b0;
            if (mm_req_o) begin
                if (!seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        chk({nm, " unexpected req"}, 32'(mm_req_o), 32'd0);
                    end else begin
                        a = sb.pop_front();
                        chk({nm, " mm_we"},    32'(mm_we_o), 32'(a.we));
                        chk({nm, " mm_addr"},  mm_addr_o,    a.addr);
                        chk({nm, " mm_be"},    32'(mm_be_o), 32'(a.be));
                        chk({nm, " mm_wdata"}, mm_wdata_o,   a.wdata);
                    end
                end
                mm_rdata_i = v.mrdata;
                mm_ack_i   = (served == v.waits);
                served++;
            end
            @(posedge clk_i); #1;
            mm_ack_i = 1'b0;
            mm_rdata_i = 32'h0BAD_0BAD;
        end
        if (!done) chk({nm, " timeout"}, 32'd1, 32'd0);
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        chk({nm, " stall cycles"}, 32'(stall), 32'(v.stall));
        chk({nm, " rdata"}, rdata_o, v.rdata);
        chk({nm, " scoreboard drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int exp_rises = 0;
        tbl[0]  = mk(1,0,3'b010,32'h100,0,32'hDEADBEEF,0, 0,32'h100,4'hF,32'h0,32'hDEADBEEF,2);
        tbl[1]  = mk(1,0,3'b000,32'h103,0,32'h80FFFF7F,3, 0,32'h100,4'hF,32'h0,32'hFFFFFF80,5);
        tbl[2]  = mk(0,1,3'b001,32'h202,32'h0000ABCD,0,1, 0,32'h200,4'hC,32'hABCDABCD,32'hFFFFFF80,3);
        tbl[3]  = mk(1,0,3'b010,32'h101,0,0,0,            1,0,0,0,32'hFFFFFF80,0);
        tbl[4]  = mk(1,0,3'b100,32'h102,0,32'h11A23344,0, 0,32'h100,4'hF,32'h0,32'h000000A2,2);
        tbl[5]  = mk(1,0,3'b001,32'h102,0,32'h80017FFF,0, 0,32'h100,4'hF,32'h0,32'hFFFF8001,2);
        tbl[6]  = mk(1,0,3'b101,32'h100,0,32'h8001F00F,2, 0,32'h100,4'hF,32'h0,32'h0000F00F,4);
        tbl[7]  = mk(0,1,3'b000,32'h305,32'h123456C3,0,2, 0,32'h304,4'h2,32'hC3C3C3C3,32'h0000F00F,4);
        tbl[8]  = mk(0,1,3'b010,32'h400,32'hCAFEF00D,0,0, 0,32'h400,4'hF,32'hCAFEF00D,32'h0000F00F,2);
        tbl[9]  = mk(1,0,3'b001,32'h201,0,0,0,            1,0,0,0,32'h0000F00F,0);
        tbl[10] = mk(1,0,3'b011,32'h000,0,0,0,            1,0,0,0,32'h0000F00F,0);
        tbl[11] = mk(1,1,3'b010,32'h010,32'h55AA55AA,32'h77777777,0,
                     0,32'h010,4'hF,32'h55AA55AA,32'h0000F00F,2);
        tbl[12] = mk(0,1,3'b001,32'h200,32'h00001234,0,0, 0,32'h200,4'h3,32'h12341234,32'h0000F00F,2);
        tbl[13] = mk(1,0,3'b000,32'h100,0,32'h0000007F,1, 0,32'h100,4'hF,32'h0,32'h0000007F,3);
        tbl[14] = mk(0,1,3'b110,32'h300,32'h1,0,0,        1,0,0,0,32'h0000007F,0);
        tbl[15] = mk(0,1,3'b001,32'h203,32'h1,0,0,        1,0,0,0,32'h0000007F,0);

        // Reset with a request already asserted: no stall, no flag, all outputs zero.
        rst_ni = 1'b0; mm_ack_i = 1'b0; mm_rdata_i = 32'h0;
        mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h1; wdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        chk("reset misaligned", 32'(misaligned_o), 32'd0);
        chk("reset busywait",   32'(busywait_o), 32'd0);
        addr_i = 32'h100;
        #1;
        chk("reset busywait valid req", 32'(busywait_o), 32'd0);
        chk("reset mm_req",   32'(mm_req_o), 32'd0);
        chk("reset mm_we",    32'(mm_we_o), 32'd0);
        chk("reset mm_addr",  mm_addr_o, 32'd0);
        chk("reset mm_be",    32'(mm_be_o), 32'd0);
        chk("reset mm_wdata", mm_wdata_o, 32'd0);
        chk("reset rdata",    rdata_o, 32'd0);
        mem_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Ops are issued back to back, so each follows the previous DONE cycle directly.
        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i]);
            if (!tbl[i].mis) exp_rises++;
        end
        chk("req count after table", 32'(req_rises), 32'(exp_rises));

        // Reset in the middle of an access abandons it; a late ack does nothing.
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
        @(negedge clk_i);
        chk("abort busywait idle", 32'(busywait_o), 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("abort req up", 32'(mm_req_o), 32'd1);
        exp_rises++;
        #2 rst_ni = 1'b0;
        #1;
        chk("abort req dropped", 32'(mm_req_o), 32'd0);
        chk("abort busywait",    32'(busywait_o), 32'd0);
        mem_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        mm_ack_i = 1'b1; mm_rdata_i = 32'hFEEDFACE;
        @(posedge clk_i); #1;
        mm_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late ack req",      32'(mm_req_o), 32'd0);
        chk("late ack busywait", 32'(busywait_o), 32'd0);
        chk("late ack rdata",    rdata_o, 32'd0);
        @(posedge clk_i); #1;
        run_op("post-reset LW",
               mk(1,0,3'b010,32'h600,0,32'h13579BDF,1, 0,32'h600,4'hF,32'h0,32'h13579BDF,3));
        exp_rises++;
        repeat (3) @(posedge clk_i);
        #1;
        chk("total req count", 32'(req_rises), 32'(exp_rises));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
